// File: rtl/storage_arbiter.sv
// Round-robin arbiter that hands one storage manager to NREQ requesters,
// issuing one command at a time and waiting (with a timeout) for completion.
module storage_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0][7:0] req_id,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 st_valid,
    output logic                 st_we,
    output logic [7:0]           st_id,
    input  logic                 st_done,
    output logic                 busy
);

    localparam int               IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [NREQ-1:0]  ONE      = NREQ'(1);
    localparam logic [IW-1:0]    LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic            we_q, we_d;
    logic [7:0]      id_q, id_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   winner;
    logic            found;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req[i] && (req_id[i] != 8'd0);
        end
    end

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IW'((int'(last_q) + off) % NREQ);
            if (!found && elig[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = 1'b0;
        valid_d = 1'b0;
        we_d    = we_q;
        id_d    = id_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (found) begin
                    state_d = ISSUE;
                    idx_d   = winner;
                    last_d  = winner;
                    grant_d = ONE << winner;
                    valid_d = 1'b1;
                    we_d    = req_we[winner];
                    id_d    = req_id[winner];
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 8'd0;
            end
            WAIT: begin
                // A completion arriving on the last allowed cycle still counts as success.
                if (st_done || (cnt_q == TMO_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    done_d  = ONE << idx_q;
                    err_d   = !st_done;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            last_q  <= LAST_RST;
            idx_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            id_q    <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign err      = err_q;
    assign st_valid = valid_q;
    assign st_we    = we_q;
    assign st_id    = id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_storage_arbiter.sv
// Bench for storage_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_storage_arbiter;

    localparam int NREQ = 3;
    localparam int TMO  = 4;

    logic            clk;
    logic            sysRst;
    logic [2:0]      req;
    logic [2:0]      reqWe;
    logic [2:0][7:0] reqId;
    logic [2:0]      grant;
    logic [2:0]      done;
    logic            err;
    logic            stValid;
    logic            stWe;
    logic [7:0]      stId;
    logic            stDone;
    logic            busy;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: who owns storage, how many cycles since the grant.
    int         mOwner = -1;
    int         mAge   = 0;
    int         mLast  = NREQ - 1;
    logic [7:0] mId    = 8'd0;
    logic       mWe    = 1'b0;
    logic [2:0] mDone  = 3'b000;
    logic       mErr   = 1'b0;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] we;
        logic [7:0] id0;
        logic [7:0] id1;
        logic [7:0] id2;
        logic       sd;
        logic [2:0] eGrant;
        logic [2:0] eDone;
        logic       eErr;
        logic       eValid;
        logic       eWe;
        logic [7:0] eId;
        logic       eBusy;
    } vec_t;

    vec_t vecs[$];

    storage_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .sys_rst  (sysRst),
        .req      (req),
        .req_we   (reqWe),
        .req_id   (reqId),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .st_valid (stValid),
        .st_we    (stWe),
        .st_id    (stId),
        .st_done  (stDone),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] r, input logic [2:0] w,
                                 input logic [7:0] i0, input logic [7:0] i1, input logic [7:0] i2,
                                 input logic sd);
        sysRst   = rst;
        req      = r;
        reqWe    = w;
        reqId[0] = i0;
        reqId[1] = i1;
        reqId[2] = i2;
        stDone   = sd;
    endtask

    // Advances the model one clock using the inputs the DUT samples at this edge.
    task automatic modelUpdate();
        int  c;
        bit  hit;
        mDone = 3'b000;
        mErr  = 1'b0;
        if (sysRst) begin
            mOwner = -1;
            mAge   = 0;
            mLast  = NREQ - 1;
            mId    = 8'd0;
            mWe    = 1'b0;
        end else if (mOwner < 0) begin
            hit = 0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (mLast + k) % NREQ;
                if (!hit && req[c] && reqId[c] != 8'd0) begin
                    hit    = 1;
                    mOwner = c;
                    mLast  = c;
                    mAge   = 0;
                    mId    = reqId[c];
                    mWe    = reqWe[c];
                end
            end
        end else if (mAge == 0) begin
            mAge = 1;
        end else if (stDone || mAge == TMO) begin
            mDone  = 3'b001 << mOwner;
            mErr   = !stDone;
            mOwner = -1;
        end else begin
            mAge++;
        end
    endtask

    task automatic checkOutput();
        logic [2:0] eGrant;
        eGrant = (mOwner >= 0) ? (3'b001 << mOwner) : 3'b000;
        checkVal("model.grant",    grant,   eGrant);
        checkVal("model.done",     done,    mDone);
        checkVal("model.err",      err,     mErr);
        checkVal("model.st_valid", stValid, (mOwner >= 0) && (mAge == 0));
        checkVal("model.st_we",    stWe,    mWe);
        checkVal("model.st_id",    stId,    mId);
        checkVal("model.busy",     busy,    mOwner >= 0);
    endtask

    task tick();
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput();
    endtask

    task doReset();
        applyStimulus(1'b1, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w, input logic [7:0] i0,
                                input logic [7:0] i2, input logic sd, input logic [2:0] eg,
                                input logic [2:0] ed, input logic ev, input logic ewe,
                                input logic [7:0] eid, input logic eb);
        vec_t v;
        v.rst = 1'b0;   v.req = r;     v.we = w;      v.id0 = i0;   v.id1 = 8'd0;
        v.id2 = i2;     v.sd = sd;     v.eGrant = eg; v.eDone = ed; v.eErr = 1'b0;
        v.eValid = ev;  v.eWe = ewe;   v.eId = eid;   v.eBusy = eb;
        return v;
    endfunction

    initial begin
        logic [2:0] expG;

        // Single read, then a stray st_done in IDLE, then an id-0 request.
        vecs.push_back(mk(3'b001, 3'b000, 8'd5, 8'd0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 8'd5, 1'b1));
        vecs.push_back(mk(3'b000, 3'b000, 8'd0, 8'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 8'd5, 1'b1));
        vecs.push_back(mk(3'b000, 3'b000, 8'd0, 8'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 8'd5, 1'b1));
        vecs.push_back(mk(3'b000, 3'b000, 8'd0, 8'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 8'd5, 1'b1));
        vecs.push_back(mk(3'b000, 3'b000, 8'd0, 8'd0, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 8'd5, 1'b0));
        vecs.push_back(mk(3'b000, 3'b000, 8'd0, 8'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 8'd5, 1'b0));
        vecs.push_back(mk(3'b100, 3'b100, 8'd0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 8'd5, 1'b0));

        applyStimulus(1'b1, 3'b111, 3'b111, 8'd1, 8'd2, 8'd3, 1'b1);
        tick();
        tick();
        checkVal("reset.grant", grant, 3'b000);
        checkVal("reset.busy", busy, 1'b0);
        checkVal("reset.st_id", stId, 8'd0);
        applyStimulus(1'b0, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 1'b0);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].rst, vecs[n].req, vecs[n].we, vecs[n].id0, vecs[n].id1,
                          vecs[n].id2, vecs[n].sd);
            tick();
            checkVal($sformatf("vec%0d.grant", n), grant, vecs[n].eGrant);
            checkVal($sformatf("vec%0d.done", n), done, vecs[n].eDone);
            checkVal($sformatf("vec%0d.err", n), err, vecs[n].eErr);
            checkVal($sformatf("vec%0d.st_valid", n), stValid, vecs[n].eValid);
            checkVal($sformatf("vec%0d.st_we", n), stWe, vecs[n].eWe);
            checkVal($sformatf("vec%0d.st_id", n), stId, vecs[n].eId);
            checkVal($sformatf("vec%0d.busy", n), busy, vecs[n].eBusy);
        end

        // Id zero is never granted.
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b0, 3'b100, 3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
            tick();
            checkVal("idzero.grant", grant, 3'b000);
            checkVal("idzero.st_valid", stValid, 1'b0);
            checkVal("idzero.busy", busy, 1'b0);
        end

        // Contention: rotation 0,1,2,0 with each grant one cycle after done.
        doReset();
        applyStimulus(1'b0, 3'b111, 3'b000, 8'd1, 8'd2, 8'd3, 1'b0);
        tick();
        expG = 3'b001;
        for (int t = 0; t < 4; t++) begin
            checkVal("rr.grant", grant, expG);
            checkVal("rr.st_valid", stValid, 1'b1);
            tick();
            stDone = 1'b1;
            tick();
            checkVal("rr.done", done, expG);
            checkVal("rr.grant_drop", grant, 3'b000);
            stDone = 1'b0;
            tick();
            expG = {expG[1:0], expG[2]};
        end

        // Timeout: write with req dropped after grant; done+err on 4th WAIT edge.
        doReset();
        applyStimulus(1'b0, 3'b001, 3'b001, 8'd9, 8'd0, 8'd0, 1'b0);
        tick();
        checkVal("tmo.st_we", stWe, 1'b1);
        applyStimulus(1'b0, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        for (int t = 0; t < 3; t++) begin
            tick();
            checkVal("tmo.done_early", done, 3'b000);
        end
        tick();
        checkVal("tmo.done", done, 3'b001);
        checkVal("tmo.err", err, 1'b1);
        tick();
        checkVal("tmo.idle_busy", busy, 1'b0);
        checkVal("tmo.err_clear", err, 1'b0);

        // Coincidence: st_done on the final timeout cycle wins.
        applyStimulus(1'b0, 3'b100, 3'b000, 8'd0, 8'd0, 8'd7, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        stDone = 1'b1;
        tick();
        checkVal("coin.done", done, 3'b100);
        checkVal("coin.err", err, 1'b0);
        stDone = 1'b0;

        // Reset during WAIT drops the transaction; next grant restarts at requester 0.
        tick();
        applyStimulus(1'b0, 3'b010, 3'b000, 8'd0, 8'd7, 8'd0, 1'b0);
        tick();
        checkVal("rstw.grant", grant, 3'b010);
        applyStimulus(1'b0, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        tick();
        sysRst = 1'b1;
        tick();
        checkVal("rstw.grant0", grant, 3'b000);
        checkVal("rstw.busy0", busy, 1'b0);
        sysRst = 1'b0;
        stDone = 1'b1;
        tick();
        checkVal("rstw.no_done", done, 3'b000);
        applyStimulus(1'b0, 3'b111, 3'b000, 8'd4, 8'd5, 8'd6, 1'b0);
        tick();
        checkVal("rstw.first", grant, 3'b001);
        checkVal("rstw.first_id", stId, 8'd4);

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          3'($urandom),
                          3'($urandom),
                          ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                          ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                          ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                          $urandom_range(0, 3) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/storage_arbiter.md
STORAGE_ARBITER -- requirements
Module: storage_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (0 = menu, 1 = history, 2 = play).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles spent waiting for st_done.
REQ-003 SHALL have port clk  in  1  the single clock for all logic.
REQ-004 SHALL have port sys_rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  in  NREQ  per-requester request level.
REQ-006 SHALL have port req_we  in  NREQ  per-requester operation select: 1 = write, 0 = read.
REQ-007 SHALL have port req_id  in  NREQ x 8  per-requester storage id; id 0 means no operation.
REQ-008 SHALL have port grant  out  NREQ  one-hot marker of the requester currently owning storage.
REQ-009 SHALL have port done  out  NREQ  one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port err  out  1  one-cycle pulse, coincident with done, on timeout.
REQ-011 SHALL have port st_valid  out  1  one-cycle command strobe to the storage manager.
REQ-012 SHALL have port st_we  out  1  latched operation, stable from st_valid until done.
REQ-013 SHALL have port st_id  out  8  latched id, stable from st_valid until done.
REQ-014 SHALL have port st_done  in  1  storage completion pulse.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, ISSUE, WAIT, and SHALL register every output.
REQ-017 A requester i is eligible when req[i]=1 and req_id[i]!=0; requests with id 0 are never granted.
REQ-018 In IDLE, when at least one requester is eligible at edge k, SHALL do the following:
- select the winner round-robin, searching from last_grant+1 modulo NREQ;
- latch the winner's index, req_we and req_id;
- enter ISSUE, with grant, st_valid, st_we, st_id and busy visible in cycle k+1.
REQ-019 ISSUE SHALL last exactly one cycle (st_valid=1 only there), then enter WAIT with the timeout counter at 0.
REQ-020 In WAIT, SHALL increment the 8-bit timeout counter each cycle; st_done sampled at edge m SHALL cause done[idx]=1, grant=0 and IDLE in cycle m+1.
REQ-021 If the counter reaches TIMEOUT without st_done, SHALL pulse done[idx] and err together for one cycle, then return to IDLE.
REQ-022 If st_done and the final timeout cycle coincide, st_done SHALL win and err SHALL stay 0.
REQ-023 SHALL update last_grant only when a grant is issued.
REQ-024 Consecutive transactions SHALL be separated by at least one IDLE cycle, giving at most one st_valid per 3 cycles.
REQ-025 SHALL ignore st_done in IDLE and ISSUE.
REQ-026 Requester inputs SHALL be ignored outside IDLE; dropping req mid-transaction SHALL NOT abort it, and done still pulses.
REQ-027 grant SHALL be one-hot or zero at all times; done SHALL be nonzero only for the granted index.

Reset
REQ-028 sys_rst sampled high SHALL force the following on the next edge, regardless of state:
- state = IDLE, timeout counter = 0, last_grant = NREQ-1;
- grant = 0, done = 0, err = 0, st_valid = 0, st_we = 0, st_id = 0, busy = 0.
REQ-029 Reset mid-transaction SHALL drop the transaction with no done pulse; a later st_done SHALL be ignored.

Verification
REQ-030 Single read: req=001, req_we=000, id0=5 at edge 0 -> grant=001, st_valid=1, st_id=5, st_we=0 in cycle 1; st_done at edge 4 -> done=001 in cycle 5, busy=0 in cycle 5.
REQ-031 Contention: req=111 held, with ids 1/2/3, from reset -> grants in order 001, 010, 100, 001; each grant follows the previous done by exactly one cycle.
REQ-032 Id zero: req=100 with id2=0 for 20 cycles -> grant stays 000, st_valid stays 0, busy stays 0.
REQ-033 Timeout: TIMEOUT=4, one write request, st_done never asserted -> done and err pulse together 4 cycles after entering WAIT; arbiter then returns to IDLE.
REQ-034 Reset mid-WAIT: sys_rst for 1 cycle during WAIT, then st_done pulses -> all outputs 0 and no done pulse; next request is granted to requester 0 first.
REQ-035 Coincidence: st_done on the final timeout cycle -> done=1, err=0.
